// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and constants for the memory bus controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GRANT  = 3'd1,
      SETUP  = 3'd2,
      STROBE = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic REQ_IF      = 1'b0;
   localparam logic REQ_LS      = 1'b1;
   localparam int   RAM_SEL_BIT = 15;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Purpose  : Fetch and load/store requester handshake into the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;

   logic        if_req;
   logic [15:0] if_addr;
   logic        if_gnt;
   logic        if_valid;
   logic [7:0]  if_rdata;

   logic        ls_req;
   logic        ls_we;
   logic [15:0] ls_addr;
   logic [7:0]  ls_wdata;
   logic        ls_gnt;
   logic        ls_valid;
   logic [7:0]  ls_rdata;
   logic        ls_err;

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
      input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata, ls_err
   );

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
      output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata, ls_err
   );

endinterface
`default_nettype wire

// File: rtl/mem_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Purpose  : Two-way round-robin arbiter between fetch and load/store ports.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb
   import mem_ctrl_pkg::*;
(
   input  wire  clk,
   input  wire  rst,
   input  wire  i_if_req,
   input  wire  i_ls_req,
   input  wire  i_arb_en,
   output logic o_req_any,
   output logic o_win_id
);

   logic r_last;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      o_win_id = REQ_IF;
      if (i_if_req && i_ls_req) begin
         o_win_id = ~r_last;
      end else if (i_ls_req) begin
         o_win_id = REQ_LS;
      end
   end

   assign o_req_any = i_if_req | i_ls_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= REQ_IF;
      end else if (i_arb_en && o_req_any) begin
         r_last <= o_win_id;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Sequences fetch and load/store accesses onto the shared ROM/RAM bus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int RD_WAIT   = 1,
   parameter int ROM_WR_EN = 1
) (
   input  wire          clk,
   input  wire          rst,
   mem_ctrl_if.slave    cpu,
   output logic         wr_en,
   output logic         rd_en,
   output logic         rom_ram,
   output logic [14:0]  address_bus,
   inout  wire  [7:0]   data_bus
);

   localparam logic [2:0] c_rd_wait   = 3'(RD_WAIT);
   localparam logic       c_rom_wr_en = (ROM_WR_EN != 0);

   state_t      r_state;
   state_t      w_next;
   logic        r_id;
   logic        r_we;
   logic        r_rom_ram;
   logic [14:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_if_rdata;
   logic [7:0]  r_ls_rdata;
   logic [2:0]  r_cnt;

   logic        w_req_any;
   logic        w_win_id;
   logic        w_arb_en;
   logic        w_gnt;
   logic        w_valid;
   logic        w_rd;
   logic        w_wr;
   logic        w_drive;
   logic        w_strobe_last;
   logic        w_rom_reject;

   assign w_arb_en      = (r_state == IDLE);
   assign w_strobe_last = (r_cnt == c_rd_wait);
   assign w_rom_reject  = r_we & ~r_rom_ram & ~c_rom_wr_en;

   mem_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_if_req  (cpu.if_req),
      .i_ls_req  (cpu.ls_req),
      .i_arb_en  (w_arb_en),
      .o_req_any (w_req_any),
      .o_win_id  (w_win_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_gnt   = 1'b0;
      w_valid = 1'b0;
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      w_drive = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req_any) w_next = GRANT;
         end
         GRANT: begin
            w_gnt  = 1'b1;
            w_next = SETUP;
         end
         SETUP: begin
            w_drive = r_we;
            w_next  = w_rom_reject ? DONE : STROBE;
         end
         STROBE: begin
            w_drive = r_we;
            w_wr    = r_we;
            w_rd    = ~r_we;
            if (w_strobe_last) w_next = DONE;
         end
         DONE: begin
            w_valid = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Request fields are taken at the end of the grant cycle, while the
   // requester is still guaranteed to be holding them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id       <= REQ_IF;
         r_we       <= 1'b0;
         r_rom_ram  <= 1'b1;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_ls_rdata <= '0;
         r_cnt      <= '0;
      end else begin
         if (r_state == IDLE && w_req_any) begin
            r_id <= w_win_id;
         end
         if (r_state == GRANT) begin
            if (r_id == REQ_LS) begin
               r_we      <= cpu.ls_we;
               r_rom_ram <= cpu.ls_addr[RAM_SEL_BIT];
               r_addr    <= cpu.ls_addr[RAM_SEL_BIT-1:0];
               r_wdata   <= cpu.ls_wdata;
            end else begin
               r_we      <= 1'b0;
               r_rom_ram <= cpu.if_addr[RAM_SEL_BIT];
               r_addr    <= cpu.if_addr[RAM_SEL_BIT-1:0];
            end
         end
         r_cnt <= (r_state == STROBE) ? r_cnt + 3'd1 : 3'd0;
         if (r_state == STROBE && w_strobe_last && !r_we) begin
            if (r_id == REQ_LS) r_ls_rdata <= data_bus;
            else                r_if_rdata <= data_bus;
         end
      end
   end

   assign wr_en       = w_wr;
   assign rd_en       = w_rd;
   assign rom_ram     = r_rom_ram;
   assign address_bus = r_addr;
   assign data_bus    = w_drive ? r_wdata : 8'hzz;

   assign cpu.if_gnt   = w_gnt   & (r_id == REQ_IF);
   assign cpu.ls_gnt   = w_gnt   & (r_id == REQ_LS);
   assign cpu.if_valid = w_valid & (r_id == REQ_IF);
   assign cpu.ls_valid = w_valid & (r_id == REQ_LS);
   assign cpu.ls_err   = w_valid & (r_id == REQ_LS) & w_rom_reject;
   assign cpu.if_rdata = r_if_rdata;
   assign cpu.ls_rdata = r_ls_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a ROM/RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_viol   = 0;
   logic mon_en = 1'b0;

   logic [7:0] mem [0:65535];

   // Main instance: RD_WAIT=1, ROM writes rejected
   mem_ctrl_if  m ();
   logic        wr_en, rd_en, rom_ram;
   logic [14:0] address_bus;
   wire  [7:0]  data_bus;

   mem_ctrl #(.RD_WAIT(1), .ROM_WR_EN(0)) u_dut (
      .clk(clk), .rst(rst), .cpu(m), .wr_en(wr_en), .rd_en(rd_en),
      .rom_ram(rom_ram), .address_bus(address_bus), .data_bus(data_bus)
   );

   for (genvar b = 0; b < 8; b++) begin : g_pu
      pullup (data_bus[b]);
   end

   assign data_bus = rd_en ? mem[{rom_ram, address_bus}] : 8'hzz;

   always @(posedge clk) begin
      if (wr_en) mem[{rom_ram, address_bus}] <= data_bus;
   end

   // Strobe-width sweep instances, read-only
   mem_ctrl_if  s0 ();
   mem_ctrl_if  s7 ();
   logic        wr0, rd0, rr0, wr7, rd7, rr7;
   logic [14:0] ab0, ab7;
   wire  [7:0]  db0, db7;

   mem_ctrl #(.RD_WAIT(0), .ROM_WR_EN(1)) u_sw0 (
      .clk(clk), .rst(rst), .cpu(s0), .wr_en(wr0), .rd_en(rd0),
      .rom_ram(rr0), .address_bus(ab0), .data_bus(db0)
   );
   mem_ctrl #(.RD_WAIT(7), .ROM_WR_EN(1)) u_sw7 (
      .clk(clk), .rst(rst), .cpu(s7), .wr_en(wr7), .rd_en(rd7),
      .rom_ram(rr7), .address_bus(ab7), .data_bus(db7)
   );
   assign db0 = rd0 ? mem[{rr0, ab0}] : 8'hzz;
   assign db7 = rd7 ? mem[{rr7, ab7}] : 8'hzz;

   // Bus invariants on the main instance
   logic        p_wr = 1'b0, p_rd = 1'b0, p_rr = 1'b1;
   logic [14:0] p_ab = '0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_en && rd_en) n_viol++;
         if ((wr_en !== p_wr || rd_en !== p_rd) && (address_bus !== p_ab || rom_ram !== p_rr)) n_viol++;
         if (rd_en && data_bus !== mem[{rom_ram, address_bus}]) n_viol++;
      end
      p_wr <= wr_en;
      p_rd <= rd_en;
      p_rr <= rom_ram;
      p_ab <= address_bus;
   end

   // One transaction on the main instance; reports timing relative to the request cycle.
   task automatic xfer(input logic ls, input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                       output int gnt_lat, output int val_lat, output int wr_cnt, output int rd_cnt,
                       output logic [7:0] rdata, output logic err, output logic [7:0] bus_wr,
                       output logic [7:0] bus_done, output logic rr, output logic [14:0] ab);
      gnt_lat = -1; val_lat = -1; wr_cnt = 0; rd_cnt = 0; rdata = '0; err = 1'b0;
      bus_wr = '0; bus_done = '0; rr = 1'b0; ab = '0;
      @(negedge clk);
      if (ls) begin
         m.ls_req = 1'b1; m.ls_we = we; m.ls_addr = addr; m.ls_wdata = wdata;
      end else begin
         m.if_req = 1'b1; m.if_addr = addr;
      end
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (gnt_lat < 0 && (ls ? m.ls_gnt : m.if_gnt)) begin
            gnt_lat = i;
            if (ls) m.ls_req = 1'b0; else m.if_req = 1'b0;
         end
         if (gnt_lat > 0 && i == gnt_lat + 1) begin
            rr = rom_ram; ab = address_bus;
         end
         if (wr_en) begin wr_cnt++; bus_wr = data_bus; end
         if (rd_en) rd_cnt++;
         if (ls ? m.ls_valid : m.if_valid) begin
            val_lat  = i;
            err      = m.ls_err;
            bus_done = data_bus;
            rdata    = ls ? m.ls_rdata : m.if_rdata;
            break;
         end
      end
      m.if_req = 1'b0;
      m.ls_req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (m.if_gnt !== 1'b0)   begin n_errors++; $display("FAIL reset_if_gnt: got %0b expected 0", m.if_gnt); end
      n_checks++; if (m.ls_gnt !== 1'b0)   begin n_errors++; $display("FAIL reset_ls_gnt: got %0b expected 0", m.ls_gnt); end
      n_checks++; if (m.if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid: got %0b expected 0", m.if_valid); end
      n_checks++; if (m.ls_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ls_valid: got %0b expected 0", m.ls_valid); end
      n_checks++; if (m.ls_err !== 1'b0)   begin n_errors++; $display("FAIL reset_ls_err: got %0b expected 0", m.ls_err); end
      n_checks++; if (m.if_rdata !== 8'h00) begin n_errors++; $display("FAIL reset_if_rdata: got %0h expected 0", m.if_rdata); end
      n_checks++; if (m.ls_rdata !== 8'h00) begin n_errors++; $display("FAIL reset_ls_rdata: got %0h expected 0", m.ls_rdata); end
      n_checks++; if ({wr_en, rd_en} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes: got %b expected 00", {wr_en, rd_en}); end
      n_checks++; if (rom_ram !== 1'b1)    begin n_errors++; $display("FAIL reset_rom_ram: got %0b expected 1", rom_ram); end
      n_checks++; if (address_bus !== 15'h0) begin n_errors++; $display("FAIL reset_address: got %0h expected 0", address_bus); end
      n_checks++; if (data_bus !== 8'hFF)  begin n_errors++; $display("FAIL reset_data_bus_released: got %0h expected pulled-up ff", data_bus); end
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [3:0] g_order, v_order;
      logic [7:0] v_data [4];
      int gcnt = 0, vcnt = 0;
      logic [7:0] exp_data;
      g_order = '0; v_order = '0;
      m.if_addr = 16'h0123; m.ls_addr = 16'h8020; m.ls_we = 1'b0;
      m.if_req = 1'b1; m.ls_req = 1'b1;
      for (int i = 0; i < 80 && vcnt < 4; i++) begin
         @(negedge clk);
         if (m.if_gnt) begin if (gcnt < 4) g_order[gcnt] = REQ_IF; gcnt++; end
         if (m.ls_gnt) begin if (gcnt < 4) g_order[gcnt] = REQ_LS; gcnt++; end
         if (gcnt >= 4) begin m.if_req = 1'b0; m.ls_req = 1'b0; end
         if (m.if_valid && vcnt < 4) begin v_order[vcnt] = REQ_IF; v_data[vcnt] = m.if_rdata; vcnt++; end
         if (m.ls_valid && vcnt < 4) begin v_order[vcnt] = REQ_LS; v_data[vcnt] = m.ls_rdata; vcnt++; end
      end
      m.if_req = 1'b0; m.ls_req = 1'b0;
      n_checks++; if (gcnt !== 4) begin n_errors++; $display("FAIL rr_grant_count: got %0d expected 4", gcnt); end
      n_checks++; if (vcnt !== 4) begin n_errors++; $display("FAIL rr_valid_count: got %0d expected 4", vcnt); end
      // LS wins the first tie, then alternation: LS, IF, LS, IF (index 0 first)
      n_checks++; if (g_order !== 4'b0101) begin n_errors++; $display("FAIL rr_grant_order: got %b expected 0101", g_order); end
      n_checks++; if (v_order !== 4'b0101) begin n_errors++; $display("FAIL rr_valid_order: got %b expected 0101", v_order); end
      for (int k = 0; k < 4; k++) begin
         exp_data = (k % 2 == 0) ? 8'h3C : 8'h5A;
         n_checks++;
         if (k < vcnt && v_data[k] !== exp_data) begin
            n_errors++; $display("FAIL rr_rdata_%0d: got %0h expected %0h", k, v_data[k], exp_data);
         end else if (k >= vcnt) begin
            n_errors++; $display("FAIL rr_rdata_%0d: got none expected %0h", k, exp_data);
         end
      end
   endtask

   task automatic test_if_read();
      int gl, vl, wc, rc; logic [7:0] rd, bw, bd; logic er, rr; logic [14:0] ab;
      xfer(REQ_IF, 1'b0, 16'h0123, 8'h00, gl, vl, wc, rc, rd, er, bw, bd, rr, ab);
      n_checks++; if (gl !== 1) begin n_errors++; $display("FAIL if_gnt_latency: got %0d expected 1", gl); end
      n_checks++; if (vl !== 5) begin n_errors++; $display("FAIL if_valid_latency: got %0d expected 5", vl); end
      n_checks++; if (rc !== 2) begin n_errors++; $display("FAIL if_rd_width: got %0d expected 2", rc); end
      n_checks++; if (wc !== 0) begin n_errors++; $display("FAIL if_no_wr: got %0d expected 0", wc); end
      n_checks++; if (rr !== 1'b0) begin n_errors++; $display("FAIL if_rom_ram: got %0b expected 0", rr); end
      n_checks++; if (ab !== 15'h0123) begin n_errors++; $display("FAIL if_address: got %0h expected 0123", ab); end
      n_checks++; if (rd !== 8'h5A) begin n_errors++; $display("FAIL if_rdata: got %0h expected 5a", rd); end
   endtask

   task automatic test_ls_write_read();
      int gl, vl, wc, rc; logic [7:0] rd, bw, bd; logic er, rr; logic [14:0] ab;
      xfer(REQ_LS, 1'b1, 16'h8010, 8'hC3, gl, vl, wc, rc, rd, er, bw, bd, rr, ab);
      n_checks++; if (gl !== 1) begin n_errors++; $display("FAIL ls_wr_gnt_latency: got %0d expected 1", gl); end
      n_checks++; if (vl !== 5) begin n_errors++; $display("FAIL ls_wr_valid_latency: got %0d expected 5", vl); end
      n_checks++; if (wc !== 2) begin n_errors++; $display("FAIL ls_wr_width: got %0d expected 2", wc); end
      n_checks++; if (rc !== 0) begin n_errors++; $display("FAIL ls_wr_no_rd: got %0d expected 0", rc); end
      n_checks++; if (rr !== 1'b1) begin n_errors++; $display("FAIL ls_wr_rom_ram: got %0b expected 1", rr); end
      n_checks++; if (ab !== 15'h0010) begin n_errors++; $display("FAIL ls_wr_address: got %0h expected 0010", ab); end
      n_checks++; if (bw !== 8'hC3) begin n_errors++; $display("FAIL ls_wr_data_bus: got %0h expected c3", bw); end
      n_checks++; if (bd !== 8'hFF) begin n_errors++; $display("FAIL ls_wr_done_released: got %0h expected pulled-up ff", bd); end
      n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL ls_wr_err: got %0b expected 0", er); end
      n_checks++; if (mem[16'h8010] !== 8'hC3) begin n_errors++; $display("FAIL ls_wr_ram_content: got %0h expected c3", mem[16'h8010]); end
      xfer(REQ_LS, 1'b0, 16'h8010, 8'h00, gl, vl, wc, rc, rd, er, bw, bd, rr, ab);
      n_checks++; if (vl !== 5) begin n_errors++; $display("FAIL ls_rd_valid_latency: got %0d expected 5", vl); end
      n_checks++; if (rc !== 2) begin n_errors++; $display("FAIL ls_rd_width: got %0d expected 2", rc); end
      n_checks++; if (rd !== 8'hC3) begin n_errors++; $display("FAIL ls_rd_rdata: got %0h expected c3", rd); end
      n_checks++; if (m.if_rdata !== 8'h5A) begin n_errors++; $display("FAIL if_rdata_hold: got %0h expected 5a", m.if_rdata); end
   endtask

   task automatic test_rom_reject();
      int gl, vl, wc, rc; logic [7:0] rd, bw, bd; logic er, rr; logic [14:0] ab;
      xfer(REQ_LS, 1'b1, 16'h0004, 8'hEE, gl, vl, wc, rc, rd, er, bw, bd, rr, ab);
      n_checks++; if (gl !== 1) begin n_errors++; $display("FAIL rej_gnt_latency: got %0d expected 1", gl); end
      n_checks++; if (vl !== 3) begin n_errors++; $display("FAIL rej_valid_latency: got %0d expected 3", vl); end
      n_checks++; if (wc !== 0) begin n_errors++; $display("FAIL rej_no_wr: got %0d expected 0", wc); end
      n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL rej_err: got %0b expected 1", er); end
      n_checks++; if (mem[16'h0004] !== 8'h77) begin n_errors++; $display("FAIL rej_rom_content: got %0h expected 77", mem[16'h0004]); end
      @(negedge clk);
      n_checks++; if (m.ls_err !== 1'b0) begin n_errors++; $display("FAIL rej_err_pulse: got %0b expected 0", m.ls_err); end
   endtask

   task automatic test_reset_mid_access();
      int gl, vl, wc, rc; logic [7:0] rd, bw, bd; logic er, rr; logic [14:0] ab;
      logic found = 1'b0;
      int seen_valid = 0;
      mon_en = 1'b0;
      @(negedge clk);
      m.if_req = 1'b1; m.if_addr = 16'h0123;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m.if_gnt) m.if_req = 1'b0;
         if (rd_en) begin found = 1'b1; break; end
      end
      m.if_req = 1'b0;
      n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rst_mid_reach_strobe: got %0b expected 1", found); end
      #1 rst = 1'b1;
      #1;
      n_checks++; if (rd_en !== 1'b0) begin n_errors++; $display("FAIL rst_mid_rd_en_async: got %0b expected 0", rd_en); end
      n_checks++; if (data_bus !== 8'hFF) begin n_errors++; $display("FAIL rst_mid_bus_released: got %0h expected pulled-up ff", data_bus); end
      n_checks++; if (address_bus !== 15'h0 || rom_ram !== 1'b1) begin
         n_errors++; $display("FAIL rst_mid_addr: got %0b/%0h expected 1/0", rom_ram, address_bus);
      end
      repeat (2) begin @(negedge clk); if (m.if_valid) seen_valid++; end
      rst = 1'b0;
      repeat (6) begin @(negedge clk); if (m.if_valid) seen_valid++; end
      n_checks++; if (seen_valid !== 0) begin n_errors++; $display("FAIL rst_mid_no_valid: got %0d expected 0", seen_valid); end
      n_checks++; if (m.if_rdata !== 8'h00) begin n_errors++; $display("FAIL rst_mid_rdata_cleared: got %0h expected 0", m.if_rdata); end
      mon_en = 1'b1;
      xfer(REQ_IF, 1'b0, 16'h0123, 8'h00, gl, vl, wc, rc, rd, er, bw, bd, rr, ab);
      n_checks++; if (vl !== 5 || rd !== 8'h5A) begin
         n_errors++; $display("FAIL rst_mid_recovery: got lat=%0d data=%0h expected lat=5 data=5a", vl, rd);
      end
   endtask

   task automatic test_rd_wait_sweep();
      int w0 = 0, w7 = 0, l0 = -1, l7 = -1;
      logic [7:0] d0 = '0, d7 = '0;
      @(negedge clk);
      s0.if_req = 1'b1; s0.if_addr = 16'h0123;
      s7.if_req = 1'b1; s7.if_addr = 16'h0123;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (s0.if_gnt) s0.if_req = 1'b0;
         if (s7.if_gnt) s7.if_req = 1'b0;
         if (rd0 || wr0) w0++;
         if (rd7 || wr7) w7++;
         if (s0.if_valid && l0 < 0) begin l0 = i; d0 = s0.if_rdata; end
         if (s7.if_valid && l7 < 0) begin l7 = i; d7 = s7.if_rdata; end
         if (l0 > 0 && l7 > 0) break;
      end
      s0.if_req = 1'b0; s7.if_req = 1'b0;
      n_checks++; if (w0 !== 1)  begin n_errors++; $display("FAIL sweep0_width: got %0d expected 1", w0); end
      n_checks++; if (l0 !== 4)  begin n_errors++; $display("FAIL sweep0_latency: got %0d expected 4", l0); end
      n_checks++; if (d0 !== 8'h5A) begin n_errors++; $display("FAIL sweep0_rdata: got %0h expected 5a", d0); end
      n_checks++; if (w7 !== 8)  begin n_errors++; $display("FAIL sweep7_width: got %0d expected 8", w7); end
      n_checks++; if (l7 !== 11) begin n_errors++; $display("FAIL sweep7_latency: got %0d expected 11", l7); end
      n_checks++; if (d7 !== 8'h5A) begin n_errors++; $display("FAIL sweep7_rdata: got %0h expected 5a", d7); end
   endtask

   task automatic test_invariants();
      @(negedge clk);
      n_checks++; if (n_viol !== 0) begin n_errors++; $display("FAIL bus_invariants: got %0d violations expected 0", n_viol); end
   endtask

   initial begin
      m.if_req = 1'b0; m.if_addr = '0; m.ls_req = 1'b0; m.ls_we = 1'b0; m.ls_addr = '0; m.ls_wdata = '0;
      s0.if_req = 1'b0; s0.if_addr = '0; s0.ls_req = 1'b0; s0.ls_we = 1'b0; s0.ls_addr = '0; s0.ls_wdata = '0;
      s7.if_req = 1'b0; s7.if_addr = '0; s7.ls_req = 1'b0; s7.ls_we = 1'b0; s7.ls_addr = '0; s7.ls_wdata = '0;
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h0123] = 8'h5A;
      mem[16'h0004] = 8'h77;
      mem[16'h8020] = 8'h3C;

      test_reset();
      test_round_robin();
      test_if_read();
      test_ls_write_read();
      test_rom_reject();
      test_reset_mid_access();
      test_rd_wait_sweep();
      test_invariants();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
